// File: rtl/width_16to8_if.sv
// Handshake bundle for the 16-to-8 width converter: 16-bit word stream in, 8-bit byte stream out.
interface width_16to8_if;
    logic        valid_in;
    logic        ready_in;
    logic [15:0] data_in;
    logic        valid_out;
    logic        ready_out;
    logic [7:0]  data_out;

    // The converter itself sits on the slave side; the environment driving it uses master.
    modport slave (
        input  valid_in,
        input  data_in,
        input  ready_out,
        output ready_in,
        output valid_out,
        output data_out
    );

    modport master (
        output valid_in,
        output data_in,
        output ready_out,
        input  ready_in,
        input  valid_out,
        input  data_out
    );
endinterface

// File: rtl/width_16to8.sv
// Serialises each accepted 16-bit word into two bytes with valid/ready flow control on both sides.
// Byte order is set by MSB_FIRST; sustains one byte per clock when downstream is always ready.
module width_16to8 #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    width_16to8_if.slave   bus
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_e;

    state_e      state_q;
    logic [15:0] word_q;
    logic        valid_q;
    logic [7:0]  data_q;

    function automatic logic [7:0] first_byte(input logic [15:0] w);
        return MSB_FIRST ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] w);
        return MSB_FIRST ? w[7:0] : w[15:8];
    endfunction

    // Upstream may hand over a new word in the same cycle the last byte of the old one leaves.
    assign bus.ready_in  = (state_q == EMPTY) || ((state_q == SECOND) && bus.ready_out);
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;

    // NOTE: every register here uses <= so all updates see the pre-edge values of state_q/word_q;
    // reset is synchronous and clears the holding register too, so no stale byte can resurface.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            word_q  <= 16'h0000;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (bus.valid_in) begin
                        word_q  <= bus.data_in;
                        state_q <= FIRST;
                        valid_q <= 1'b1;
                        data_q  <= first_byte(bus.data_in);
                    end
                end
                FIRST: begin
                    if (bus.ready_out) begin
                        state_q <= SECOND;
                        data_q  <= second_byte(word_q);
                    end
                end
                SECOND: begin
                    if (bus.ready_out) begin
                        if (bus.valid_in) begin
                            word_q  <= bus.data_in;
                            state_q <= FIRST;
                            data_q  <= first_byte(bus.data_in);
                        end else begin
                            state_q <= EMPTY;
                            valid_q <= 1'b0;
                            data_q  <= 8'h00;
                        end
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                    data_q  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_width_16to8.sv
// Self-checking bench: both byte orders driven with identical stimulus, checked each cycle
// against a word-queue reference model.
module tb_width_16to8;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [15:0] data_in;
    logic        ready_out;

    int n_cmp = 0;
    int n_bad = 0;
    bit timeout_flag = 1'b0;

    width_16to8_if bus_m ();
    width_16to8_if bus_l ();

    assign bus_m.valid_in  = valid_in;
    assign bus_m.data_in   = data_in;
    assign bus_m.ready_out = ready_out;
    assign bus_l.valid_in  = valid_in;
    assign bus_l.data_in   = data_in;
    assign bus_l.ready_out = ready_out;

    width_16to8 #(.MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
    width_16to8 #(.MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Byte k (0 = sent first) of word w under the given order.
    function automatic logic [7:0] byte_of(input logic [15:0] w, input bit msb_first, input int k);
        logic hi;
        hi = msb_first ? (k == 0) : (k == 1);
        return hi ? w[15:8] : w[7:0];
    endfunction

    // Reference model: queue of accepted words and how many bytes of the head have left.
    logic [15:0] wq[$];
    int          sent = 0;
    bit          armed = 1'b0;
    bit          stall_m = 1'b0, stall_l = 1'b0;
    logic [7:0]  held_m, held_l;

    always @(negedge clk) begin
        logic exp_v, exp_r;
        logic [7:0] exp_dm, exp_dl;
        if (armed) begin
            exp_v  = (wq.size() != 0);
            exp_r  = !exp_v || ((sent == 1) && ready_out);
            exp_dm = exp_v ? byte_of(wq[0], 1'b1, sent) : 8'h00;
            exp_dl = exp_v ? byte_of(wq[0], 1'b0, sent) : 8'h00;
            check("valid_out_msb", 16'(bus_m.valid_out), 16'(exp_v));
            check("data_out_msb",  16'(bus_m.data_out),  16'(exp_dm));
            check("ready_in_msb",  16'(bus_m.ready_in),  16'(exp_r));
            check("valid_out_lsb", 16'(bus_l.valid_out), 16'(exp_v));
            check("data_out_lsb",  16'(bus_l.data_out),  16'(exp_dl));
            check("ready_in_lsb",  16'(bus_l.ready_in),  16'(exp_r));
            check("handshake_timeout", 16'(timeout_flag), 16'd0);
            if (stall_m)
                check("stall_hold_msb", {7'd0, bus_m.valid_out, bus_m.data_out}, {8'h01, held_m});
            if (stall_l)
                check("stall_hold_lsb", {7'd0, bus_l.valid_out, bus_l.data_out}, {8'h01, held_l});
            stall_m = bus_m.valid_out && !ready_out;
            stall_l = bus_l.valid_out && !ready_out;
            held_m  = bus_m.data_out;
            held_l  = bus_l.data_out;
            if (rst) begin
                wq.delete();
                sent    = 0;
                stall_m = 1'b0;
                stall_l = 1'b0;
            end else begin
                if (exp_v && ready_out) begin
                    if (sent == 0) sent = 1;
                    else begin
                        void'(wq.pop_front());
                        sent = 0;
                    end
                end
                if (valid_in && exp_r) wq.push_back(data_in);
            end
        end else if (rst) begin
            armed = 1'b1;
        end
    end

    // Presents each word in turn, keeping valid_in high until the model-agnostic ready_in shows it taken.
    task automatic send_words(input logic [15:0] words[$]);
        foreach (words[i]) begin
            int n;
            valid_in = 1'b1;
            data_in  = words[i];
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus_m.ready_in && n < 50);
            if (n >= 50) timeout_flag = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        valid_in  = 1'b0;
        data_in   = 16'h0000;
        ready_out = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-word: A5C3 held in FIRST, then discarded.
        ready_out = 1'b0;
        send_words('{16'hA5C3});
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ready_out = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        send_words('{16'h1234});
        repeat (4) @(posedge clk);
        #1;
        send_words('{16'hBEEF});
        repeat (4) @(posedge clk);
        #1;
        send_words('{16'h0102, 16'h0304, 16'h0506});
        repeat (4) @(posedge clk);
        #1;

        // Downstream stall: 3 cycles in FIRST, 2 in SECOND.
        ready_out = 1'b0;
        send_words('{16'hCAFE});
        repeat (3) @(posedge clk);
        #1 ready_out = 1'b1;
        @(posedge clk);
        #1 ready_out = 1'b0;
        repeat (2) @(posedge clk);
        #1 ready_out = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 10000; i++) begin
            valid_in  = 1'($urandom % 2);
            data_in   = 16'($urandom);
            ready_out = 1'($urandom % 2);
            @(posedge clk);
            #1;
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
